// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and constants for the unified memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  // Returned to the requester on an aborted access; deliberately equal to the CPU's EOF marker
  localparam logic [31:0] ABORT_DATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: saturating busy-cycle counter that flags a stalled memory access
//   clk, rst_n  clock and asynchronous active-low reset
//   i_clear     reload the count with zero (asserted on each grant)
//   i_inc       count one busy cycle without m_ready
//   o_expired   count has reached TIMEOUT
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT + 2);
  logic [CW-1:0] r_cnt;
  assign o_expired = r_cnt == CW'(TIMEOUT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_inc && !o_expired) r_cnt <= r_cnt + CW'(1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and load/store
//   i_req/i_addr -> i_rdata/i_valid          fetch requester
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_valid  data requester (priority)
//   err                                      pulses with the valid of an aborted access
//   m_addr/m_wdata/m_read/m_write, m_rdata/m_ready  memory side
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              err,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_read,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);
  localparam int SW = $clog2(STARVE_MAX + 2);
  state_t r_state, w_next;
  logic [SW-1:0] r_starve;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata, r_i_rdata, r_d_rdata;
  logic r_m_read, r_m_write, r_i_valid, r_d_valid, r_err;
  logic w_grant_i, w_grant_d, w_done, w_abort, w_end, w_expired, w_starved;
  assign w_starved = r_starve == SW'(STARVE_MAX);
  assign w_end = w_done || w_abort;
  always_comb begin
    w_next = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    w_done = 1'b0;
    w_abort = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant_d = d_req && !(i_req && w_starved);
        w_grant_i = i_req && !w_grant_d;
        w_next = w_grant_d ? BUSY_D : w_grant_i ? BUSY_I : IDLE;
      end
      BUSY_I, BUSY_D: begin
        // m_ready on the expiry cycle still wins: completion beats abort
        w_done = m_ready;
        w_abort = !m_ready && w_expired;
        w_next = (m_ready || w_expired) ? IDLE : r_state;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // Counts data grants that bypassed a waiting fetch; saturation forces the next fetch through
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_starve <= '0;
    else if (w_grant_i) r_starve <= '0;
    else if (w_grant_d && i_req && !w_starved) r_starve <= r_starve + SW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_m_addr <= '0;
      r_m_wdata <= '0;
      r_m_read <= 1'b0;
      r_m_write <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_i_valid <= w_end && r_state == BUSY_I;
      r_d_valid <= w_end && r_state == BUSY_D;
      r_err <= w_abort;
      if (w_grant_i) begin
        r_m_addr <= i_addr;
        r_m_wdata <= '0;
        r_m_read <= 1'b1;
        r_m_write <= 1'b0;
      end else if (w_grant_d) begin
        r_m_addr <= d_addr;
        r_m_wdata <= d_wdata;
        r_m_read <= !d_we;
        r_m_write <= d_we;
      end else if (w_end) begin
        r_m_read <= 1'b0;
        r_m_write <= 1'b0;
      end
      if (w_end && r_state == BUSY_I) r_i_rdata <= w_abort ? DATA_W'(ABORT_DATA) : m_rdata;
      // A completed write leaves load data untouched; an abort always reports the marker
      if (w_end && r_state == BUSY_D && (w_abort || r_m_read))
        r_d_rdata <= w_abort ? DATA_W'(ABORT_DATA) : m_rdata;
    end
  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst_n(rst_n),
    .i_clear(w_grant_i || w_grant_d),
    .i_inc(r_state != IDLE && !m_ready),
    .o_expired(w_expired)
  );
  assign m_addr = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_read = r_m_read;
  assign m_write = r_m_write;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign i_valid = r_i_valid;
  assign d_valid = r_d_valid;
  assign err = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ready = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic i_valid, d_valid, err, m_read, m_write;
  typedef struct {
    logic is_d;
    logic [31:0] data;
    logic err;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_err = 0;
  logic [31:0] exp_drd = '0;
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .err(err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Scoreboard consumer: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk)
    if (rst_n && (i_valid || d_valid)) begin
      chk("one_valid", {i_valid, d_valid} == 2'b11, 0);
      if (sb.size() == 0) chk("unexpected_valid", {i_valid, d_valid}, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_kind", d_valid, e.is_d);
        chk("sb_data", e.is_d ? d_rdata : i_rdata, e.data);
        chk("sb_err", err, e.err);
      end
    end
  task automatic access(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int lat);
    exp_t e;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    chk("pre_grant_idle", {m_read, m_write}, 0);
    e.is_d = is_d;
    e.err = 1'b0;
    e.data = (is_d && we) ? exp_drd : rd;
    if (is_d && !we) exp_drd = rd;
    sb.push_back(e);
    for (int k = 1; k <= lat; k++) begin
      tick;
      chk("strobe", {m_read, m_write}, is_d ? {!we, we} : 2'b10);
      chk("addr", m_addr, addr);
      if (is_d && we) chk("wdata", m_wdata, wd);
      if (k == lat) begin
        m_ready = 1'b1; m_rdata = rd;
      end
    end
    tick;
    chk("strobe_drop", {m_read, m_write}, 0);
    chk("valid", is_d ? d_valid : i_valid, 1);
    i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0; m_rdata = '0;
    tick;
    chk("valid_pulse", {i_valid, d_valid, err}, 0);
  endtask
  initial begin
    exp_t e;
    int n;
    logic got;
    tick;
    tick;
    chk("rst_strobes", {m_read, m_write, i_valid, d_valid, err}, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    rst_n = 1'b1;
    tick;
    // single fetch, memory answers on the third strobe cycle
    access(1'b0, 1'b0, 32'h3000, 32'h0, 32'h8C22_0004, 3);
    chk("i_rdata_hold", i_rdata, 32'h8C22_0004);
    // load to give d_rdata a known nonzero value, then a store that must not disturb it
    access(1'b1, 1'b0, 32'h200, 32'h0, 32'h1234_5678, 2);
    access(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, 1);
    chk("write_keeps_rdata", d_rdata, 32'h1234_5678);
    // both requesters held: D,D,D,D,I repeating
    i_req = 1'b1; i_addr = 32'h7000;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h800; d_wdata = 32'h1111_2222;
    m_ready = 1'b1; m_rdata = 32'h0BAD_F00D;
    for (int g = 0; g < 10; g++) begin
      tick;
      chk($sformatf("grant_%0d", g), {m_read, m_write}, (g % 5 != 4) ? 2'b01 : 2'b10);
      e.is_d = g % 5 != 4;
      e.data = e.is_d ? exp_drd : 32'h0BAD_F00D;
      e.err = 1'b0;
      sb.push_back(e);
      tick;
    end
    i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0; m_rdata = '0;
    tick;
    // load that memory never answers
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    e.is_d = 1'b1; e.data = 32'hFFFF_FFFF; e.err = 1'b1;
    sb.push_back(e);
    exp_drd = 32'hFFFF_FFFF;
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick;
      if (d_valid) begin
        got = 1'b1;
        chk("to_err", err, 1);
        chk("to_rdata", d_rdata, 32'hFFFF_FFFF);
        chk("to_strobe_cycles", n, 16);
        chk("to_strobe_drop", m_read, 0);
      end else if (m_read) n++;
    end
    chk("to_seen", got, 1);
    d_req = 1'b0;
    tick;
    chk("to_err_pulse", err, 0);
    access(1'b0, 1'b0, 32'h3004, 32'h0, 32'hAC22_0008, 1);
    // ready on the expiry cycle completes normally
    access(1'b1, 1'b0, 32'h600, 32'h0, 32'h600D_CAFE, 16);
    // reset while fetch is in flight
    i_req = 1'b1; i_addr = 32'h5000;
    tick;
    chk("rst_busy", m_read, 1);
    tick;
    rst_n = 1'b0;
    #1;
    chk("rst_async_strobe", m_read, 0);
    chk("rst_async_rdata", {i_rdata, d_rdata}, 0);
    exp_drd = '0;
    tick;
    tick;
    chk("rst_no_valid", {i_valid, d_valid, err}, 0);
    rst_n = 1'b1;
    tick;
    chk("regrant_strobe", m_read, 1);
    chk("regrant_addr", m_addr, 32'h5000);
    e.is_d = 1'b0; e.data = 32'h1357_9BDF; e.err = 1'b0;
    sb.push_back(e);
    m_ready = 1'b1; m_rdata = 32'h1357_9BDF;
    tick;
    chk("regrant_valid", i_valid, 1);
    i_req = 1'b0; m_ready = 1'b0;
    tick;
    tick;
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
